// File: rtl/ldpc_qc_encoder_pkg.sv
// Shared LDPC definitions: encoder FSM states and the base-matrix shift/connection functions.
package ldpc_qc_encoder_pkg;

  typedef enum logic {
    S_INFO   = 1'b0,
    S_PARITY = 1'b1
  } enc_state_t;

  // Circulant rotation for row i, info column j
  function automatic int shift(input int i, input int j, input int z);
    return (3 * i + 5 * j + 1) % z;
  endfunction

  // Base-matrix connectivity: row i uses column j
  function automatic logic conn(input int i, input int j);
    return ((i + j) % 3) != 2;
  endfunction

endpackage

// File: rtl/ldpc_cyclic_shifter.sv
// Combinational right cyclic rotation: data_out[b] = data_in[(b+shift) mod Z].
// Zero latency, no flow control.
module ldpc_cyclic_shifter #(
  parameter int Z = 8,
  localparam int SW = (Z > 1) ? $clog2(Z) : 1
) (
  input  logic [Z-1:0]  data_in,
  input  logic [SW-1:0] shift,
  output logic [Z-1:0]  data_out
);

  always_comb begin
    data_out = '0;
    for (int b = 0; b < Z; b++) begin
      data_out[b] = data_in[(b + int'(shift)) % Z];
    end
  end

endmodule

// File: rtl/ldpc_qc_encoder.sv
// Systematic QC-LDPC encoder: passes KB info blocks through (1-cycle latency), then emits MB parity blocks.
// Single output register; in_ready and parity emission stall while the register is held by out_ready=0.
module ldpc_qc_encoder
  import ldpc_qc_encoder_pkg::*;
#(
  parameter int Z  = 8,
  parameter int KB = 4,
  parameter int MB = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [Z-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [Z-1:0] out_data,
  output logic         out_parity,
  output logic         out_last
);

  localparam int CW = (KB > 1) ? $clog2(KB) : 1;
  localparam int PW = (MB > 1) ? $clog2(MB) : 1;
  localparam int SW = (Z > 1) ? $clog2(Z) : 1;

  enc_state_t    state, state_nxt;
  logic [CW-1:0] col;
  logic [PW-1:0] pidx;
  logic [Z-1:0]  acc     [MB];
  logic [Z-1:0]  rot_out [MB];
  logic          out_free, info_ld, par_ld, last_col, last_par;

  assign out_free = !out_valid || out_ready;
  assign last_col = (col == CW'(KB - 1));
  assign last_par = (pidx == PW'(MB - 1));

  for (genvar i = 0; i < MB; i++) begin : g_row
    logic [SW-1:0] sh;
    assign sh = SW'(shift(i, int'(col), Z));
    ldpc_cyclic_shifter #(.Z(Z)) u_shifter (
      .data_in  (in_data),
      .shift    (sh),
      .data_out (rot_out[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INFO;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INFO:   if (info_ld && last_col) state_nxt = S_PARITY;
      S_PARITY: if (par_ld && last_par)  state_nxt = S_INFO;
      default:  state_nxt = S_INFO;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    info_ld  = 1'b0;
    par_ld   = 1'b0;
    case (state)
      S_INFO: begin
        in_ready = !rst && out_free;
        info_ld  = in_valid && in_ready;
      end
      S_PARITY: par_ld = out_free;
      default: ;
    endcase
  end

  // The last info block folds into acc on its accept edge, so parity can follow immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      pidx       <= '0;
      out_valid  <= 1'b0;
      out_parity <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      for (int i = 0; i < MB; i++) acc[i] <= '0;
    end else if (info_ld) begin
      out_data   <= in_data;
      out_valid  <= 1'b1;
      out_parity <= 1'b0;
      out_last   <= 1'b0;
      col        <= last_col ? '0 : col + 1'b1;
      for (int i = 0; i < MB; i++) begin
        if (conn(i, int'(col))) acc[i] <= acc[i] ^ rot_out[i];
      end
    end else if (par_ld) begin
      out_data   <= acc[pidx];
      out_valid  <= 1'b1;
      out_parity <= 1'b1;
      out_last   <= last_par;
      if (last_par) begin
        pidx <= '0;
        for (int i = 0; i < MB; i++) acc[i] <= '0;
      end else begin
        pidx <= pidx + 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ldpc_qc_encoder.sv
// Directed bench for ldpc_qc_encoder (Z=8, KB=4, MB=2) with hand-computed parity.
module tb_ldpc_qc_encoder;

  localparam int Z  = 8;
  localparam int KB = 4;
  localparam int MB = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [Z-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [Z-1:0] out_data;
  logic         out_parity;
  logic         out_last;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] src_q [$];
  logic [7:0] got_dat [$];
  logic       got_par [$];
  logic       got_last [$];

  ldpc_qc_encoder #(.Z(Z), .KB(KB), .MB(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_parity (out_parity),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Feed src_q and record output transfers; inputs change on the falling edge only.
  task automatic drive(input int n_in, input int n_out, input int stall_len, input logic [7:0] hold_val);
    int sent = 0;
    int cyc = 0;
    int stall_rem = stall_len;
    while ((sent < n_in || got_dat.size() < n_out) && cyc < 200) begin
      @(negedge clk);
      in_valid  = (sent < n_in);
      in_data   = (sent < n_in) ? src_q[sent] : 8'h00;
      out_ready = !(stall_rem > 0 && out_valid);
      #1;
      if (!out_ready) begin
        stall_rem--;
        chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        chk("stall_hold", {24'b0, out_data}, {24'b0, hold_val});
      end
      if (out_valid && out_ready) begin
        got_dat.push_back(out_data);
        got_par.push_back(out_parity);
        got_last.push_back(out_last);
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    chk("timeout", {31'b0, (cyc < 200)}, 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    src_q.delete();
  endtask

  task automatic check_out(input string tag, input int off,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                           input logic [7:0] d3, input logic [7:0] p0, input logic [7:0] p1);
    logic [7:0] exp [6];
    logic [7:0] a_dat;
    logic       a_par, a_last;
    exp[0] = d0; exp[1] = d1; exp[2] = d2; exp[3] = d3; exp[4] = p0; exp[5] = p1;
    for (int i = 0; i < 6; i++) begin
      if (off + i < got_dat.size()) begin
        a_dat  = got_dat[off+i];
        a_par  = got_par[off+i];
        a_last = got_last[off+i];
      end else begin
        a_dat  = 'x;
        a_par  = 1'bx;
        a_last = 1'bx;
      end
      chk($sformatf("%s_dat%0d", tag, i), {24'b0, a_dat}, {24'b0, exp[i]});
      chk($sformatf("%s_par%0d", tag, i), {31'b0, a_par}, {31'b0, (i >= 4)});
      chk($sformatf("%s_last%0d", tag, i), {31'b0, a_last}, {31'b0, (i == 5)});
    end
  endtask

  task automatic clear_got();
    got_dat.delete();
    got_par.delete();
    got_last.delete();
  endtask

  initial begin
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_parity", {31'b0, out_parity}, 32'd0);
    chk("rst_out_last", {31'b0, out_last}, 32'd0);
    chk("rst_out_data", {24'b0, out_data}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single bit in column 0: rot(01,1)=80 for row 0, rot(01,4)=10 for row 1
    src_q = '{8'h01, 8'h00, 8'h00, 8'h00};
    drive(4, 6, 0, 8'h00);
    check_out("unit", 0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h80, 8'h10);
    clear_got();

    // Three connected columns per row: FF^FF^FF = FF
    src_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    drive(4, 6, 0, 8'h00);
    check_out("ones", 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    clear_got();

    src_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    drive(4, 6, 0, 8'h00);
    check_out("zero", 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    clear_got();

    // Backpressure right after the first block
    src_q = '{8'h01, 8'h00, 8'h00, 8'h00};
    drive(4, 6, 5, 8'h01);
    check_out("stall", 0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h80, 8'h10);
    clear_got();

    // Partial frame of FF blocks abandoned by reset
    src_q = '{8'hFF, 8'hFF};
    drive(2, 0, 0, 8'h00);
    clear_got();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    chk("midrst_hold_valid", {31'b0, out_valid}, 32'd0);
    rst = 1'b0;
    src_q = '{8'h01, 8'h00, 8'h00, 8'h00};
    drive(4, 6, 0, 8'h00);
    check_out("after_rst", 0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h80, 8'h10);
    clear_got();

    // Back-to-back frames must not share accumulator state
    src_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    drive(8, 12, 0, 8'h00);
    check_out("b2b_a", 0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h80, 8'h10);
    check_out("b2b_b", 6, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    chk("b2b_count", got_dat.size(), 32'd12);
    clear_got();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
